// File: rtl/spwm_capture.sv
// SPWM gate-signal capture: measures upper-switch on-time per leg each carrier
// period and reconstructs the normalised leg voltage in Q4.28, with shoot-through flags.
module spwm_capture #(
    parameter int                 PERIOD = 10000,
    parameter logic signed [31:0] KSCALE = 32'sd53687,
    parameter int                 CW     = 14
) (
    input  logic               clk,
    input  logic               res,
    input  logic               sync,
    input  logic               Sau,
    input  logic               Sal,
    input  logic               Sbu,
    input  logic               Sbl,
    input  logic               Scu,
    input  logic               Scl,
    output logic signed [31:0] va,
    output logic signed [31:0] vb,
    output logic signed [31:0] vc,
    output logic               valid,
    output logic [2:0]         fault
);

    localparam logic [CW-1:0]     LAST = CW'(PERIOD - 1);
    localparam logic [31:0]       KU   = KSCALE;
    localparam logic signed [31:0] VMAX = 32'sh1000_0000;
    localparam logic signed [31:0] VMIN = 32'shF000_0000;

    logic [5:0]         w_gate;
    logic [2:0]         w_up;
    logic [2:0]         w_lo;
    logic               w_end;
    logic signed [31:0] w_v [3];

    logic [5:0]         r_s1;
    logic [5:0]         r_s2;
    logic [CW-1:0]      r_wcnt;
    logic [CW-1:0]      r_h   [3];
    logic [CW-1:0]      r_cap [3];
    logic               r_cap_v;
    logic signed [31:0] r_v   [3];
    logic               r_valid;
    logic [2:0]         r_fault;

    assign w_gate = {Scl, Scu, Sbl, Sbu, Sal, Sau};
    assign w_up   = {r_s2[4], r_s2[2], r_s2[0]};
    assign w_lo   = {r_s2[5], r_s2[3], r_s2[1]};
    assign w_end  = (r_wcnt == LAST);

    function automatic logic signed [31:0] conv(input logic [CW-1:0] cap);
        logic [31:0]        prod;
        logic signed [31:0] v;
        prod = 32'(cap) * KU;
        v    = $signed(prod - 32'h1000_0000);
        if (v > VMAX)
            return VMAX;
        else if (v < VMIN)
            return VMIN;
        return v;
    endfunction

    always_comb begin
        for (int i = 0; i < 3; i++)
            w_v[i] = conv(r_cap[i]);
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_s1    <= '0;
            r_s2    <= '0;
            r_wcnt  <= '0;
            r_cap_v <= 1'b0;
            r_valid <= 1'b0;
            r_fault <= '0;
            for (int i = 0; i < 3; i++) begin
                r_h[i]   <= '0;
                r_cap[i] <= '0;
                r_v[i]   <= '0;
            end
        end else begin
            r_s1    <= w_gate;
            r_s2    <= r_s1;
            r_fault <= r_fault | (w_up & w_lo);
            r_cap_v <= w_end;
            r_valid <= r_cap_v;
            // a sync landing on the last cycle still closes the window normally
            if (w_end || sync)
                r_wcnt <= '0;
            else
                r_wcnt <= r_wcnt + CW'(1);
            for (int i = 0; i < 3; i++) begin
                if (w_end) begin
                    r_cap[i] <= r_h[i] + CW'(w_up[i]);
                    r_h[i]   <= '0;
                end else if (sync) begin
                    r_h[i] <= '0;
                end else begin
                    r_h[i] <= r_h[i] + CW'(w_up[i]);
                end
                if (r_cap_v)
                    r_v[i] <= w_v[i];
            end
        end
    end

    assign va    = r_v[0];
    assign vb    = r_v[1];
    assign vc    = r_v[2];
    assign valid = r_valid;
    assign fault = r_fault;

endmodule

// File: tb/tb_spwm_capture.sv
// Randomised bench for spwm_capture against a cycle-level reference of
// window totals, 2-stage input delay and Q4.28 conversion arithmetic.
module tb_spwm_capture;

    localparam int P  = 1000;
    localparam int K  = 536871;
    localparam int CW = 10;

    logic               clk = 1'b0;
    logic               res = 1'b0;
    logic               sync = 1'b0;
    logic               Sau = 1'b0, Sal = 1'b0;
    logic               Sbu = 1'b0, Sbl = 1'b0;
    logic               Scu = 1'b0, Scl = 1'b0;
    logic signed [31:0] va, vb, vc;
    logic               valid;
    logic [2:0]         fault;

    spwm_capture #(
        .PERIOD(P),
        .KSCALE(32'sd536871),
        .CW    (CW)
    ) dut (
        .clk  (clk),
        .res  (res),
        .sync (sync),
        .Sau  (Sau),
        .Sal  (Sal),
        .Sbu  (Sbu),
        .Sbl  (Sbl),
        .Scu  (Scu),
        .Scl  (Scl),
        .va   (va),
        .vb   (vb),
        .vc   (vc),
        .valid(valid),
        .fault(fault)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    typedef struct {
        longint due;
        int     t0;
        int     t1;
        int     t2;
    } res_t;

    res_t        q[$];
    longint      edge_n = 0;
    int          mwin   = 0;
    int          mh[3];
    logic [5:0]  dly[2];
    logic [31:0] ev[3];
    bit          evalid = 0;
    logic [2:0]  efault = '0;

    function automatic logic [31:0] volt(input int tot);
        longint v;
        v = longint'(tot) * K - 268435456;
        if (v > 268435456)
            v = 268435456;
        if (v < -268435456)
            v = -268435456;
        return 32'(v);
    endfunction

    // one clock: drive on the falling edge, advance the model at the rising edge, check
    task automatic cyc(input bit r, input bit s, input logic [5:0] g);
        logic [5:0] sy;
        res_t       e;
        @(negedge clk);
        res  = r;
        sync = s;
        {Scl, Scu, Sbl, Sbu, Sal, Sau} = g;
        @(posedge clk);
        edge_n++;
        if (!r) begin
            mwin   = 0;
            mh     = '{0, 0, 0};
            dly    = '{6'd0, 6'd0};
            q.delete();
            evalid = 0;
            ev     = '{32'd0, 32'd0, 32'd0};
            efault = '0;
        end else begin
            sy = dly[1];
            evalid = 0;
            if (q.size() > 0 && q[0].due == edge_n) begin
                e = q.pop_front();
                ev = '{volt(e.t0), volt(e.t1), volt(e.t2)};
                evalid = 1;
            end
            for (int l = 0; l < 3; l++)
                if (sy[2*l] && sy[2*l+1])
                    efault[l] = 1'b1;
            if (mwin == P - 1) begin
                e.due = edge_n + 1;
                e.t0  = mh[0] + int'(sy[0]);
                e.t1  = mh[1] + int'(sy[2]);
                e.t2  = mh[2] + int'(sy[4]);
                q.push_back(e);
                mh   = '{0, 0, 0};
                mwin = 0;
            end else if (s) begin
                mh   = '{0, 0, 0};
                mwin = 0;
            end else begin
                for (int l = 0; l < 3; l++)
                    mh[l] += int'(sy[2*l]);
                mwin++;
            end
            dly[1] = dly[0];
            dly[0] = g;
        end
        #1;
        chk("valid", 32'(valid), 32'(evalid));
        chk("fault", 32'(fault), 32'(efault));
        chk("va", va, ev[0]);
        chk("vb", vb, ev[1]);
        chk("vc", vc, ev[2]);
    endtask

    function automatic logic [5:0] pat(input int k, input int da,
                                       input int db, input int dc);
        int d[3];
        logic [5:0] g;
        d = '{da, db, dc};
        g = '0;
        for (int l = 0; l < 3; l++) begin
            g[2*l]   = (k < d[l]);
            g[2*l+1] = (k > d[l]);
        end
        return g;
    endfunction

    task automatic run_pat(input int n, input int da, input int db,
                           input int dc, input int ph);
        for (int i = 0; i < n; i++)
            cyc(1'b1, 1'b0, pat((i + ph) % P, da, db, dc));
    endtask

    task automatic run_to(input int pos, input logic [5:0] g);
        for (int i = 0; i < 2 * P && mwin != pos; i++)
            cyc(1'b1, 1'b0, g);
        chk("reach_pos", 32'(mwin), 32'(pos));
    endtask

    initial begin
        int k;
        dly = '{6'd0, 6'd0};
        mh  = '{0, 0, 0};
        ev  = '{32'd0, 32'd0, 32'd0};

        for (int i = 0; i < 3; i++)
            cyc(1'b0, 1'b0, 6'b000000);

        run_pat(3 * P, P, 0, P / 2, 0);
        chk("full_on_va", va, 32'h1000_0000);
        chk("full_off_vb", vb, 32'hF000_0000);
        chk("half_vc", vc, 32'h0000_002C);

        for (int w = 0; w < 4; w++)
            run_pat(P, $urandom_range(0, P), $urandom_range(0, P),
                    $urandom_range(0, P), $urandom_range(0, P - 1));
        run_pat(P, 0, P, 1, 7);
        run_pat(P, P - 1, 1, P, 3);

        run_to(300, 6'b011001);
        cyc(1'b1, 1'b1, 6'b011001);
        k = 0;
        do begin
            cyc(1'b1, 1'b0, 6'b011001);
            k++;
        end while (!valid && k < P + 10);
        chk("sync_latency", 32'(k), 32'(P + 1));

        run_to(P - 1, 6'b100110);
        cyc(1'b1, 1'b1, 6'b100110);
        run_pat(3, 0, 0, 0, 0);

        for (int i = 0; i < 40; i++)
            cyc(1'b1, 1'b1, 6'b010101);
        chk("held_sync_novalid", 32'(valid), 32'd0);
        run_pat(P + 10, 200, 400, 600, 0);

        cyc(1'b1, 1'b0, 6'b000011);
        for (int i = 0; i < 5; i++)
            cyc(1'b1, 1'b0, 6'b000001);
        chk("fault_a", 32'(fault), 32'd1);
        run_pat(50, 100, 900, 500, 11);
        cyc(1'b1, 1'b0, 6'b110000);
        for (int i = 0; i < 5; i++)
            cyc(1'b1, 1'b0, 6'b010000);
        chk("fault_ca", 32'(fault), 32'd5);

        run_to(700, 6'b011010);
        for (int i = 0; i < 3; i++)
            cyc(1'b0, 1'b0, 6'b011010);
        chk("reset_fault", 32'(fault), 32'd0);
        chk("reset_va", va, 32'd0);
        run_pat(2 * P + 500, 750, 250, 999, 0);

        for (int w = 0; w < 5; w++) begin
            int da, db, dc, ph;
            da = $urandom_range(0, P);
            db = $urandom_range(0, P);
            dc = $urandom_range(0, P);
            ph = $urandom_range(0, P - 1);
            for (int i = 0; i < P; i++)
                cyc(1'b1, ($urandom_range(0, 1999) == 0),
                    pat((i + ph) % P, da, db, dc));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
